// File: rtl/mem_access_pkg.sv
// rtl/mem_access_pkg.sv - size codes, FSM states and sizing helpers for mem_access_unit
package mem_access_pkg;

    localparam logic [1:0] SIZE_8    = 2'd0;
    localparam logic [1:0] SIZE_16   = 2'd1;
    localparam logic [1:0] SIZE_32   = 2'd2;
    localparam logic [1:0] SIZE_RSVD = 2'd3;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ISSUE0,
        ST_WAIT0,
        ST_ISSUE1,
        ST_WAIT1,
        ST_RESP
    } state_t;

    // Byte capacity of a memory of the given number of 32-bit words
    function automatic logic [33:0] mem_bytes_of(input int unsigned words);
        return {2'b00, words} << 2;
    endfunction

    // Access width in bytes; the reserved code traps before this matters
    function automatic logic [2:0] size_bytes(input logic [1:0] size);
        case (size)
            SIZE_8:  return 3'd1;
            SIZE_16: return 3'd2;
            default: return 3'd4;
        endcase
    endfunction

    // Per-byte expanded mask covering the low n bytes
    function automatic logic [31:0] lane_mask(input logic [1:0] size);
        case (size)
            SIZE_8:  return 32'h0000_00FF;
            SIZE_16: return 32'h0000_FFFF;
            default: return 32'hFFFF_FFFF;
        endcase
    endfunction

endpackage

// File: rtl/mem_access_unit_if.sv
// rtl/mem_access_unit_if.sv - request/response and Memory command bundles for mem_access_unit

interface mem_req_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_store;
    logic [1:0]  req_size;
    logic        req_signed;
    logic [31:0] req_base;
    logic [31:0] req_offset;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_trap;

    modport master (
        output req_valid, req_store, req_size, req_signed, req_base, req_offset, req_wdata,
        input  req_ready, resp_valid, resp_rdata, resp_trap
    );
    modport slave (
        input  req_valid, req_store, req_size, req_signed, req_base, req_offset, req_wdata,
        output req_ready, resp_valid, resp_rdata, resp_trap
    );
endinterface

interface mem_bus_if;
    logic        mem_cmd_start;
    logic        mem_cmd_write;
    logic        mem_cmd_ready;
    logic [31:0] mem_addr;
    logic [31:0] mem_rdata;
    logic        mem_rdata_ready;
    logic [31:0] mem_wdata;
    logic [31:0] mem_wmask;

    modport master (
        output mem_cmd_start, mem_cmd_write, mem_addr, mem_wdata, mem_wmask,
        input  mem_cmd_ready, mem_rdata, mem_rdata_ready
    );
    modport slave (
        input  mem_cmd_start, mem_cmd_write, mem_addr, mem_wdata, mem_wmask,
        output mem_cmd_ready, mem_rdata, mem_rdata_ready
    );
endinterface

// File: rtl/mem_lane_align.sv
// rtl/mem_lane_align.sv - split detect, store lane shift/mask and load extract/extend
module mem_lane_align
    import mem_access_pkg::*;
(
    input  logic [1:0]  off,
    input  logic [1:0]  size,
    input  logic        sign_ext,
    input  logic [31:0] wdata,
    input  logic [31:0] lane0,
    input  logic [31:0] lane1,
    output logic        split,
    output logic [63:0] d64,
    output logic [63:0] m64,
    output logic [31:0] rdata
);

    logic [2:0]  n;
    logic [31:0] nmask;
    logic [4:0]  sh;
    logic [31:0] v;

    // Two-word window: stores shift up into it, loads shift down out of it
    always_comb begin
        n     = size_bytes(size);
        nmask = lane_mask(size);
        sh    = {off, 3'b000};
        split = ({1'b0, off} + n) > 3'd4;
        d64   = {32'd0, wdata & nmask} << sh;
        m64   = {32'd0, nmask} << sh;
        v     = 32'({lane1, lane0} >> sh);
        case (size)
            SIZE_8:  rdata = {{24{sign_ext & v[7]}}, v[7:0]};
            SIZE_16: rdata = {{16{sign_ext & v[15]}}, v[15:0]};
            default: rdata = v;
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// rtl/mem_access_unit.sv - linear-memory load/store initiator issuing word-aligned Memory ops
module mem_access_unit
    import mem_access_pkg::*;
#(
    parameter int MEMORY_SIZE = 2048
) (
    input  logic       clk,
    input  logic       rst_n,
    mem_req_if.slave   req,
    mem_bus_if.master  mem
);

    localparam logic [33:0] MEM_BYTES = mem_bytes_of(MEMORY_SIZE);

    state_t      state;
    logic [1:0]  off_r;
    logic [1:0]  size_r;
    logic        sign_r;
    logic        store_r;
    logic        split_r;
    logic [31:0] wdata_r;
    logic [31:0] lane0_r;

    logic [32:0] ea;
    logic [33:0] ea_end;
    logic        trap_now;
    logic        idle;
    logic [1:0]  al_off;
    logic [1:0]  al_size;
    logic        al_sign;
    logic [31:0] al_wdata;
    logic [31:0] al_lane0;
    logic        al_split;
    logic [63:0] al_d64;
    logic [63:0] al_m64;
    logic [31:0] al_rdata;

    // Address check on the live request; the aligner sees the live request while idle so
    // word0 data/mask can be registered on the accept edge, and the held op otherwise
    always_comb begin
        ea       = {1'b0, req.req_base} + {1'b0, req.req_offset};
        ea_end   = {1'b0, ea} + {31'd0, size_bytes(req.req_size)};
        trap_now = ea[32] | (ea_end > MEM_BYTES) | (req.req_size == SIZE_RSVD);
        idle     = (state == ST_IDLE);
        al_off   = idle ? ea[1:0]        : off_r;
        al_size  = idle ? req.req_size   : size_r;
        al_sign  = idle ? req.req_signed : sign_r;
        al_wdata = idle ? req.req_wdata  : wdata_r;
        al_lane0 = (state == ST_WAIT0) ? mem.mem_rdata : lane0_r;
    end

    mem_lane_align u_align (
        .off      (al_off),
        .size     (al_size),
        .sign_ext (al_sign),
        .wdata    (al_wdata),
        .lane0    (al_lane0),
        .lane1    (mem.mem_rdata),
        .split    (al_split),
        .d64      (al_d64),
        .m64      (al_m64),
        .rdata    (al_rdata)
    );

    // Request FSM with registered handshake and Memory command outputs
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state             <= ST_IDLE;
            req.req_ready     <= 1'b1;
            req.resp_valid    <= 1'b0;
            req.resp_rdata    <= '0;
            req.resp_trap     <= 1'b0;
            mem.mem_cmd_start <= 1'b0;
            mem.mem_cmd_write <= 1'b0;
            mem.mem_addr      <= '0;
            mem.mem_wdata     <= '0;
            mem.mem_wmask     <= '0;
            off_r             <= '0;
            size_r            <= '0;
            sign_r            <= 1'b0;
            store_r           <= 1'b0;
            split_r           <= 1'b0;
            wdata_r           <= '0;
            lane0_r           <= '0;
        end else begin
            req.resp_valid <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (req.req_valid && req.req_ready) begin
                        req.req_ready <= 1'b0;
                        off_r         <= ea[1:0];
                        size_r        <= req.req_size;
                        sign_r        <= req.req_signed;
                        store_r       <= req.req_store;
                        wdata_r       <= req.req_wdata;
                        split_r       <= al_split;
                        if (trap_now) begin
                            state          <= ST_RESP;
                            req.resp_valid <= 1'b1;
                            req.resp_trap  <= 1'b1;
                            req.resp_rdata <= '0;
                        end else begin
                            state             <= ST_ISSUE0;
                            mem.mem_cmd_start <= 1'b1;
                            mem.mem_cmd_write <= req.req_store;
                            mem.mem_addr      <= {ea[31:2], 2'b00};
                            mem.mem_wdata     <= al_d64[31:0];
                            mem.mem_wmask     <= al_m64[31:0];
                        end
                    end
                end
                ST_ISSUE0: begin
                    if (mem.mem_cmd_ready) begin
                        mem.mem_cmd_start <= 1'b0;
                        state             <= ST_WAIT0;
                    end
                end
                ST_WAIT0: begin
                    if (mem.mem_rdata_ready) begin
                        lane0_r <= mem.mem_rdata;
                        if (split_r) begin
                            state             <= ST_ISSUE1;
                            mem.mem_cmd_start <= 1'b1;
                            mem.mem_addr      <= mem.mem_addr + 32'd4;
                            mem.mem_wdata     <= al_d64[63:32];
                            mem.mem_wmask     <= al_m64[63:32];
                        end else begin
                            state          <= ST_RESP;
                            req.resp_valid <= 1'b1;
                            req.resp_trap  <= 1'b0;
                            req.resp_rdata <= store_r ? 32'd0 : al_rdata;
                        end
                    end
                end
                ST_ISSUE1: begin
                    if (mem.mem_cmd_ready) begin
                        mem.mem_cmd_start <= 1'b0;
                        state             <= ST_WAIT1;
                    end
                end
                ST_WAIT1: begin
                    if (mem.mem_rdata_ready) begin
                        state          <= ST_RESP;
                        req.resp_valid <= 1'b1;
                        req.resp_trap  <= 1'b0;
                        req.resp_rdata <= store_r ? 32'd0 : al_rdata;
                    end
                end
                default: begin
                    state         <= ST_IDLE;
                    req.req_ready <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// tb/tb_mem_access_unit.sv - scoreboard bench for mem_access_unit with Memory responder model
module tb_mem_access_unit;

    localparam int MEMORY_SIZE = 2048;
    localparam int MEM_BYTES   = MEMORY_SIZE * 4;

    typedef struct {
        logic [31:0] addr;
        logic        write;
        logic [31:0] wdata;
        logic [31:0] wmask;
    } cmd_t;
    typedef struct {
        logic [31:0] rdata;
        logic        trap;
    } resp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    mem_req_if rq ();
    mem_bus_if mb ();

    mem_access_unit #(.MEMORY_SIZE(MEMORY_SIZE)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .req   (rq),
        .mem   (mb)
    );

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] init_byte(input int a);
        return 8'(a * 37 + 11);
    endfunction

    // Memory responder: one outstanding op, full writes/reads take 1+ cycles, partial writes 2+
    logic [31:0] mem_words [MEMORY_SIZE];
    logic        mem_inited = 1'b0;
    logic        mem_busy = 1'b0;
    int          mem_cnt = 0;
    logic [31:0] p_addr = '0, p_wdata = '0, p_wmask = '0;
    logic        p_write = 1'b0;
    logic [31:0] m_rdata = '0;
    logic        m_rdy = 1'b0;
    logic        stall_dir = 1'b0, stall_rnd = 1'b0, rand_en = 1'b0;

    assign mb.mem_rdata       = m_rdata;
    assign mb.mem_rdata_ready = m_rdy;
    assign mb.mem_cmd_ready   = !mem_busy && !stall_dir && !stall_rnd;

    always @(posedge clk) begin
        if (!mem_inited) begin
            for (int w = 0; w < MEMORY_SIZE; w++)
                mem_words[w] <= {init_byte(4*w+3), init_byte(4*w+2), init_byte(4*w+1), init_byte(4*w)};
            mem_inited <= 1'b1;
        end else if (mem_busy) begin
            if (mem_cnt <= 1) begin
                mem_busy <= 1'b0;
                m_rdy    <= 1'b1;
                if (p_write)
                    mem_words[p_addr[12:2]] <= (mem_words[p_addr[12:2]] & ~p_wmask) | (p_wdata & p_wmask);
                else
                    m_rdata <= mem_words[p_addr[12:2]];
            end else begin
                mem_cnt <= mem_cnt - 1;
            end
        end else if (mb.mem_cmd_start && mb.mem_cmd_ready) begin
            mem_busy <= 1'b1;
            m_rdy    <= 1'b0;
            p_addr   <= mb.mem_addr;
            p_write  <= mb.mem_cmd_write;
            p_wdata  <= mb.mem_wdata;
            p_wmask  <= mb.mem_wmask;
            mem_cnt  <= ((mb.mem_cmd_write && mb.mem_wmask != 32'hFFFF_FFFF) ? 2 : 1)
                        + (rand_en ? int'($urandom_range(0, 2)) : 0);
        end
    end

    initial forever begin
        @(posedge clk);
        #1;
        stall_rnd = rand_en && ($urandom_range(0, 3) == 0);
    end

    // Reference model: byte-addressed linear memory
    logic [7:0] ref_mem [MEM_BYTES];
    cmd_t  exp_cmd [$];
    resp_t exp_resp [$];

    task automatic model_push(input logic st, input logic [1:0] sz, input logic sg,
                              input logic [31:0] b, input logic [31:0] o, input logic [31:0] wd);
        logic [63:0] ea;
        int n, a, k, lane, ncmd;
        logic [31:0] m [2];
        logic [31:0] d [2];
        logic [31:0] val;
        resp_t r;
        cmd_t c;
        ea = {32'd0, b} + {32'd0, o};
        n = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
        r.rdata = '0;
        r.trap  = 1'b0;
        if (sz == 2'd3 || ea > 64'hFFFF_FFFF || ea + 64'(n) > 64'(MEM_BYTES)) begin
            r.trap = 1'b1;
            exp_resp.push_back(r);
            return;
        end
        m[0] = '0; m[1] = '0; d[0] = '0; d[1] = '0; val = '0; k = 0;
        for (int i = 0; i < n; i++) begin
            a = int'(ea) + i;
            k = a / 4 - int'(ea) / 4;
            lane = a % 4;
            m[k] |= 32'hFF << (8 * lane);
            d[k] |= {24'd0, wd[8*i +: 8]} << (8 * lane);
            if (st) ref_mem[a] = wd[8*i +: 8];
            else    val |= {24'd0, ref_mem[a]} << (8 * i);
        end
        if (!st && sg && n < 4 && val[8*n-1]) val |= 32'hFFFF_FFFF << (8 * n);
        ncmd = k + 1;
        for (int j = 0; j < ncmd; j++) begin
            c.addr  = 32'((int'(ea) / 4 + j) * 4);
            c.write = st;
            c.wdata = d[j];
            c.wmask = m[j];
            exp_cmd.push_back(c);
        end
        if (!st) r.rdata = val;
        exp_resp.push_back(r);
    endtask

    // Monitor: Memory command handshakes, command stability under backpressure, responses
    int cmd_seen = 0, resp_seen = 0, resp_cyc = 0, stable_cnt = 0;
    logic prev_wait = 1'b0, prev_resp = 1'b0, pw = 1'b0;
    logic [31:0] pa = '0, pd = '0, pm = '0;
    cmd_t  mc;
    resp_t mr;

    always @(negedge clk) begin
        if (rst_n) begin
            if (prev_resp) chk("resp_one_cycle", rq.resp_valid, 1'b0);
            if (prev_wait) begin
                stable_cnt++;
                chk("stall_start_held", mb.mem_cmd_start, 1'b1);
                chk("stall_addr_stable", mb.mem_addr, pa);
                chk("stall_cmd_stable", {mb.mem_cmd_write, mb.mem_wdata, mb.mem_wmask}, {pw, pd, pm});
            end
            if (mb.mem_cmd_start && mb.mem_cmd_ready) begin
                cmd_seen++;
                chk("cmd_expected", 64'(exp_cmd.size() != 0), 1);
                if (exp_cmd.size() != 0) begin
                    mc = exp_cmd.pop_front();
                    chk("cmd_addr", mb.mem_addr, mc.addr);
                    chk("cmd_write", mb.mem_cmd_write, mc.write);
                    if (mc.write) begin
                        chk("cmd_wmask", mb.mem_wmask, mc.wmask);
                        chk("cmd_wdata", mb.mem_wdata, mc.wdata);
                    end
                end
            end
            if (rq.resp_valid) begin
                resp_seen++;
                resp_cyc = cyc;
                chk("ready_low_in_resp", rq.req_ready, 1'b0);
                chk("resp_expected", 64'(exp_resp.size() != 0), 1);
                if (exp_resp.size() != 0) begin
                    mr = exp_resp.pop_front();
                    chk("resp_trap", rq.resp_trap, mr.trap);
                    chk("resp_rdata", rq.resp_rdata, mr.rdata);
                end
            end
            prev_wait = mb.mem_cmd_start && !mb.mem_cmd_ready;
            prev_resp = rq.resp_valid;
            pa = mb.mem_addr; pd = mb.mem_wdata; pm = mb.mem_wmask; pw = mb.mem_cmd_write;
        end else begin
            prev_wait = 1'b0;
            prev_resp = 1'b0;
        end
    end

    task automatic wait_accept(output logic ok, output int t0);
        ok = 1'b0;
        t0 = 0;
        for (int g = 0; g < 300; g++) begin
            @(negedge clk);
            if (rq.req_ready) begin
                ok = 1'b1;
                t0 = cyc;
                break;
            end
        end
        chk("req_accepted", ok, 1'b1);
    endtask

    task automatic do_req(input logic st, input logic [1:0] sz, input logic sg,
                          input logic [31:0] b, input logic [31:0] o, input logic [31:0] wd,
                          output int lat, output int ncmd);
        logic ok;
        int t0, n0, c0;
        lat = -1;
        ncmd = -1;
        rq.req_valid = 1'b1; rq.req_store = st; rq.req_size = sz; rq.req_signed = sg;
        rq.req_base = b; rq.req_offset = o; rq.req_wdata = wd;
        wait_accept(ok, t0);
        n0 = resp_seen;
        c0 = cmd_seen;
        if (ok) model_push(st, sz, sg, b, o, wd);
        @(posedge clk);
        #1;
        rq.req_valid = 1'b0;
        if (!ok) return;
        for (int g = 0; g < 300 && resp_seen == n0; g++) begin
            @(negedge clk);
            #1;
        end
        chk("resp_arrived", 64'(resp_seen != n0), 1);
        lat = resp_cyc - t0;
        ncmd = cmd_seen - c0;
    endtask

    int lat, nc, s0, c0, t0;
    logic ok;
    logic [1:0] sz;
    logic [31:0] b, o;

    initial begin
        for (int a = 0; a < MEM_BYTES; a++) ref_mem[a] = init_byte(a);
        rq.req_valid = 1'b0; rq.req_store = 1'b0; rq.req_size = 2'd0; rq.req_signed = 1'b0;
        rq.req_base = '0; rq.req_offset = '0; rq.req_wdata = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_req_ready", rq.req_ready, 1'b1);
        chk("rst_resp_valid", rq.resp_valid, 1'b0);
        chk("rst_resp_rdata", rq.resp_rdata, 32'd0);
        chk("rst_resp_trap", rq.resp_trap, 1'b0);
        chk("rst_cmd_start", mb.mem_cmd_start, 1'b0);
        chk("rst_cmd_write", mb.mem_cmd_write, 1'b0);
        chk("rst_addr", mb.mem_addr, 32'd0);
        chk("rst_wdata", mb.mem_wdata, 32'd0);
        chk("rst_wmask", mb.mem_wmask, 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        // Aligned word store and load
        do_req(1'b1, 2'd2, 1'b0, 32'h10, 32'h0, 32'hDEADBEEF, lat, nc);
        chk("store32_cmds", nc, 1);
        do_req(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, 32'h0, lat, nc);
        chk("load32_cmds", nc, 1);
        chk("load32_latency", lat, 4);

        // Sub-word store and signed/unsigned loads
        do_req(1'b1, 2'd0, 1'b0, 32'h10, 32'h3, 32'h1234_5680, lat, nc);
        do_req(1'b0, 2'd0, 1'b1, 32'h13, 32'h0, 32'h0, lat, nc);
        do_req(1'b0, 2'd0, 1'b0, 32'h11, 32'h2, 32'h0, lat, nc);

        // Word straddling two Memory words
        do_req(1'b1, 2'd2, 1'b0, 32'h0E, 32'h0, 32'h1122_3344, lat, nc);
        chk("split_store_cmds", nc, 2);
        do_req(1'b0, 2'd2, 1'b0, 32'h0C, 32'h2, 32'h0, lat, nc);
        chk("split_load_cmds", nc, 2);
        do_req(1'b0, 2'd1, 1'b1, 32'h0F, 32'h0, 32'h0, lat, nc);

        // Bounds traps
        do_req(1'b0, 2'd2, 1'b0, 32'(MEM_BYTES - 2), 32'h0, 32'h0, lat, nc);
        chk("trap_latency", lat, 1);
        chk("trap_no_cmd", nc, 0);
        do_req(1'b0, 2'd0, 1'b0, 32'hFFFF_FFFF, 32'h2, 32'h0, lat, nc);
        chk("trap_carry_no_cmd", nc, 0);
        do_req(1'b1, 2'd3, 1'b0, 32'h20, 32'h0, 32'h0, lat, nc);
        chk("trap_size3_no_cmd", nc, 0);
        do_req(1'b0, 2'd2, 1'b0, 32'(MEM_BYTES - 4), 32'h0, 32'h0, lat, nc);
        chk("last_word_cmds", nc, 1);

        // Memory backpressure with stale rdata_ready from the previous op
        stall_dir = 1'b1;
        s0 = stable_cnt;
        fork
            do_req(1'b1, 2'd1, 1'b0, 32'h20, 32'h1, 32'hCAFE_A55A, lat, nc);
            begin
                repeat (7) @(posedge clk);
                #1;
                stall_dir = 1'b0;
            end
        join
        chk("stall_hold_cycles", 64'(stable_cnt - s0 >= 4), 1);
        do_req(1'b0, 2'd1, 1'b0, 32'h21, 32'h0, 32'h0, lat, nc);

        // Reset while waiting on the second half of a split load
        rq.req_valid = 1'b1; rq.req_store = 1'b0; rq.req_size = 2'd2; rq.req_signed = 1'b0;
        rq.req_base = 32'h0E; rq.req_offset = 32'h0; rq.req_wdata = '0;
        c0 = cmd_seen;
        wait_accept(ok, t0);
        if (ok) model_push(1'b0, 2'd2, 1'b0, 32'h0E, 32'h0, 32'h0);
        @(posedge clk);
        #1;
        rq.req_valid = 1'b0;
        for (int g = 0; g < 300 && cmd_seen < c0 + 2; g++) begin
            @(negedge clk);
            #1;
        end
        chk("reset_test_two_cmds", cmd_seen - c0, 2);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        if (exp_resp.size() != 0) void'(exp_resp.pop_back());
        repeat (2) begin
            @(negedge clk);
            chk("midop_reset_no_resp", rq.resp_valid, 1'b0);
        end
        chk("midop_reset_ready", rq.req_ready, 1'b1);
        chk("midop_reset_cmd_start", mb.mem_cmd_start, 1'b0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        do_req(1'b0, 2'd2, 1'b0, 32'h0E, 32'h0, 32'h0, lat, nc);
        chk("post_reset_cmds", nc, 2);

        // Randomized traffic with random backpressure and Memory latency
        rand_en = 1'b1;
        for (int k = 0; k < 300; k++) begin
            int sel;
            sel = int'($urandom_range(0, 9));
            sz = ($urandom_range(0, 15) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
            if (sel < 7) begin
                b = $urandom_range(0, 60);
                o = $urandom_range(0, 3);
            end else if (sel < 9) begin
                b = 32'(MEM_BYTES) - $urandom_range(1, 8);
                o = $urandom_range(0, 4);
            end else begin
                b = 32'hFFFF_FFFF - $urandom_range(0, 3);
                o = $urandom_range(0, 8);
            end
            do_req(1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)), b, o, $urandom(), lat, nc);
        end
        rand_en = 1'b0;
        repeat (5) @(posedge clk);
        @(negedge clk);
        chk("cmd_queue_drained", exp_cmd.size(), 0);
        chk("resp_queue_drained", exp_resp.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
